// File: rtl/rc5_core_param.sv
// Iterative RC5-W/R/b cipher core with on-chip key expansion and valid/ready streaming.
// One key-schedule step or one full cipher round per clock.
module rc5_core_param #(
    parameter int W          = 16,
    parameter int KEY_BYTES  = 16,
    parameter int MAX_ROUNDS = 20,
    parameter int ROUND_W    = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   key_load,
    input  logic [8*KEY_BYTES-1:0] key,
    input  logic [ROUND_W-1:0]     num_rounds,
    output logic                   key_ready,
    output logic                   cfg_err,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   mode,
    input  logic [2*W-1:0]         d_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*W-1:0]         d_out,
    output logic                   busy
);

    localparam int WB    = W / 8;
    localparam int C_RAW = (KEY_BYTES + WB - 1) / WB;
    localparam int C     = (C_RAW < 1) ? 1 : C_RAW;
    localparam int T_MAX = 2 * MAX_ROUNDS + 2;
    localparam int N_MAX = (T_MAX > C) ? T_MAX : C;
    localparam int IW    = $clog2(T_MAX);
    localparam int JW    = (C > 1) ? $clog2(C) : 1;
    localparam int KW    = $clog2(3 * N_MAX + 1);
    localparam int LW    = $clog2(W);
    localparam logic [31:0] MAX_R = 32'(MAX_ROUNDS);

    localparam logic [63:0] P64 = (W == 16) ? 64'h0000_0000_0000_B7E1 :
                                  (W == 32) ? 64'h0000_0000_B7E1_5163 : 64'hB7E1_5162_8AED_2A6B;
    localparam logic [63:0] Q64 = (W == 16) ? 64'h0000_0000_0000_9E37 :
                                  (W == 32) ? 64'h0000_0000_9E37_79B9 : 64'h9E37_79B9_7F4A_7C15;
    localparam logic [W-1:0] P = P64[W-1:0];
    localparam logic [W-1:0] Q = Q64[W-1:0];

    typedef enum logic [2:0] {IDLE, KEY_INIT, KEY_MIX, READY, WHITEN, ROUND, OUT} state_t;

    function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [LW-1:0] n);
        logic [2*W-1:0] d;
        d = {x, x} << n;
        return d[2*W-1:W];
    endfunction

    function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input logic [LW-1:0] n);
        logic [2*W-1:0] d;
        d = {x, x} >> n;
        return d[W-1:0];
    endfunction

    state_t             state;
    logic [W-1:0]       s_tab [T_MAX];
    logic [W-1:0]       l_tab [C];
    logic [ROUND_W-1:0] r_lat, rnd;
    logic               dec;
    logic [W-1:0]       ra, rb, s_acc;
    logic [IW-1:0]      i_idx;
    logic [JW-1:0]      j_idx;
    logic [KW-1:0]      k_cnt;

    logic               rounds_ok;
    logic [C*W-1:0]     key_pad;
    logic [IW-1:0]      t_last, ev_idx, od_idx;
    logic [KW-1:0]      t_k, n_k, k_last;
    logic [W-1:0]       s_ev, s_od, mix_a, mix_b, ab_sum;
    logic [W-1:0]       ea, eb, da, db, wa, wb;

    assign rounds_ok = (32'(num_rounds) <= MAX_R);
    assign in_ready  = (state == READY) && !key_load;
    assign busy      = (state != IDLE) && (state != READY);

    always_comb begin
        key_pad = '0;
        key_pad[8*KEY_BYTES-1:0] = key;
    end

    // Schedule bounds: t = 2R+2 entries, 3*max(t,c) mixing steps
    assign t_last = IW'({r_lat, 1'b1});
    assign t_k    = KW'({r_lat, 1'b1}) + KW'(1);
    assign n_k    = (t_k > KW'(C)) ? t_k : KW'(C);
    assign k_last = KW'(3) * n_k - KW'(1);

    assign mix_a  = rotl(s_tab[i_idx] + ra + rb, LW'(3));
    assign ab_sum = mix_a + rb;
    assign mix_b  = rotl(l_tab[j_idx] + ab_sum, ab_sum[LW-1:0]);

    assign ev_idx = IW'({rnd, 1'b0});
    assign od_idx = IW'({rnd, 1'b1});
    assign s_ev   = s_tab[ev_idx];
    assign s_od   = s_tab[od_idx];
    assign ea     = rotl(ra ^ rb, rb[LW-1:0]) + s_ev;
    assign eb     = rotl(rb ^ ea, ea[LW-1:0]) + s_od;
    assign db     = rotr(rb - s_od, ra[LW-1:0]) ^ ra;
    assign da     = rotr(ra - s_ev, db[LW-1:0]) ^ db;
    assign wa     = dec ? (ra - s_tab[0]) : (ra + s_tab[0]);
    assign wb     = dec ? (rb - s_tab[1]) : (rb + s_tab[1]);

    // Key tables carry no reset; they are rebuilt by every accepted key_load
    always_ff @(posedge clk) begin
        if (key_load) begin
            if (rounds_ok) begin
                for (int unsigned k = 0; k < C; k++) begin
                    l_tab[k] <= key_pad[k*W +: W];
                end
            end
        end else if (state == KEY_INIT) begin
            s_tab[i_idx] <= s_acc;
        end else if (state == KEY_MIX) begin
            s_tab[i_idx] <= mix_a;
            l_tab[j_idx] <= mix_b;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            key_ready <= 1'b0;
            cfg_err   <= 1'b0;
            out_valid <= 1'b0;
            d_out     <= '0;
            r_lat     <= '0;
            rnd       <= '0;
            dec       <= 1'b0;
            ra        <= '0;
            rb        <= '0;
            s_acc     <= '0;
            i_idx     <= '0;
            j_idx     <= '0;
            k_cnt     <= '0;
        end else if (key_load) begin
            key_ready <= 1'b0;
            out_valid <= 1'b0;
            if (!rounds_ok) begin
                cfg_err <= 1'b1;
                state   <= IDLE;
            end else begin
                cfg_err <= 1'b0;
                r_lat   <= num_rounds;
                i_idx   <= '0;
                s_acc   <= P;
                state   <= KEY_INIT;
            end
        end else begin
            case (state)
                KEY_INIT: begin
                    s_acc <= s_acc + Q;
                    if (i_idx == t_last) begin
                        i_idx <= '0;
                        j_idx <= '0;
                        k_cnt <= '0;
                        ra    <= '0;
                        rb    <= '0;
                        state <= KEY_MIX;
                    end else begin
                        i_idx <= i_idx + IW'(1);
                    end
                end
                KEY_MIX: begin
                    ra    <= mix_a;
                    rb    <= mix_b;
                    i_idx <= (i_idx == t_last) ? '0 : i_idx + IW'(1);
                    j_idx <= (j_idx == JW'(C - 1)) ? '0 : j_idx + JW'(1);
                    if (k_cnt == k_last) begin
                        key_ready <= 1'b1;
                        state     <= READY;
                    end else begin
                        k_cnt <= k_cnt + KW'(1);
                    end
                end
                READY: begin
                    if (in_valid) begin
                        ra  <= d_in[W-1:0];
                        rb  <= d_in[2*W-1:W];
                        dec <= mode;
                        if (!mode) begin
                            rnd   <= ROUND_W'(1);
                            state <= WHITEN;
                        end else begin
                            rnd   <= r_lat;
                            state <= (r_lat == '0) ? WHITEN : ROUND;
                        end
                    end
                end
                WHITEN: begin
                    ra <= wa;
                    rb <= wb;
                    if (dec || r_lat == '0) begin
                        d_out     <= {wb, wa};
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end else begin
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    if (!dec) begin
                        ra <= ea;
                        rb <= eb;
                        if (rnd == r_lat) begin
                            d_out     <= {eb, ea};
                            out_valid <= 1'b1;
                            state     <= OUT;
                        end else begin
                            rnd <= rnd + ROUND_W'(1);
                        end
                    end else begin
                        ra <= da;
                        rb <= db;
                        if (rnd == ROUND_W'(1)) state <= WHITEN;
                        else                    rnd   <= rnd - ROUND_W'(1);
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= READY;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rc5_core_param.sv
// Bench for rc5_core_param: W=16 and W=32 instances checked against a
// behavioural RC5 model (loops over plain arrays, modular arithmetic).
module tb_rc5_core_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic         kl16, kr16, ce16, iv16, ir16, md16, ov16, or16, bz16;
    logic [127:0] key16;
    logic [4:0]   nr16;
    logic [31:0]  di16, do16;

    logic         kl32, kr32, ce32, iv32, ir32, md32, ov32, or32, bz32;
    logic [127:0] key32;
    logic [4:0]   nr32;
    logic [63:0]  di32, do32;

    rc5_core_param #(.W(16), .KEY_BYTES(16), .MAX_ROUNDS(20), .ROUND_W(5)) dut16 (
        .clk(clk), .rst(rst), .key_load(kl16), .key(key16), .num_rounds(nr16),
        .key_ready(kr16), .cfg_err(ce16), .in_valid(iv16), .in_ready(ir16),
        .mode(md16), .d_in(di16), .out_valid(ov16), .out_ready(or16),
        .d_out(do16), .busy(bz16));

    rc5_core_param #(.W(32), .KEY_BYTES(16), .MAX_ROUNDS(20), .ROUND_W(5)) dut32 (
        .clk(clk), .rst(rst), .key_load(kl32), .key(key32), .num_rounds(nr32),
        .key_ready(kr32), .cfg_err(ce32), .in_valid(iv32), .in_ready(ir32),
        .mode(md32), .d_in(di32), .out_valid(ov32), .out_ready(or32),
        .d_out(do32), .busy(bz32));

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    logic [63:0] ms [0:41];
    logic [63:0] ml [0:31];

    function automatic logic [63:0] msk(input int w);
        return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    endfunction

    function automatic logic [63:0] mrotl(input logic [63:0] x, input logic [63:0] n, input int w);
        int s;
        s = int'(n % 64'(w));
        if (s == 0) return x;
        return ((x << s) | (x >> (w - s))) & msk(w);
    endfunction

    function automatic logic [63:0] mrotr(input logic [63:0] x, input logic [63:0] n, input int w);
        int s;
        s = int'(n % 64'(w));
        if (s == 0) return x;
        return ((x >> s) | (x << (w - s))) & msk(w);
    endfunction

    function automatic void model_ks(input logic [255:0] k, input int kb, input int w, input int r);
        int t, c, n, i, j;
        logic [63:0] p, q, a, b, m;
        m = msk(w);
        t = 2 * r + 2;
        c = (kb * 8 + w - 1) / w;
        if (c < 1) c = 1;
        n = (t > c) ? t : c;
        case (w)
            16:      begin p = 64'hB7E1;     q = 64'h9E37;     end
            32:      begin p = 64'hB7E15163; q = 64'h9E3779B9; end
            default: begin p = 64'hB7E151628AED2A6B; q = 64'h9E3779B97F4A7C15; end
        endcase
        for (int x = 0; x < 32; x++) ml[x] = '0;
        for (int x = 0; x < kb; x++)
            ml[(x * 8) / w] = ml[(x * 8) / w] | (64'(k[8*x +: 8]) << ((x * 8) % w));
        for (int x = 0; x < t; x++) ms[x] = (p + 64'(x) * q) & m;
        a = '0; b = '0; i = 0; j = 0;
        for (int s = 0; s < 3 * n; s++) begin
            a = mrotl((ms[i] + a + b) & m, 64'd3, w);
            ms[i] = a;
            b = mrotl((ml[j] + a + b) & m, a + b, w);
            ml[j] = b;
            i = (i + 1) % t;
            j = (j + 1) % c;
        end
    endfunction

    function automatic logic [127:0] model_enc(input logic [63:0] a0, input logic [63:0] b0,
                                               input int w, input int r);
        logic [63:0] a, b, m;
        m = msk(w);
        a = (a0 + ms[0]) & m;
        b = (b0 + ms[1]) & m;
        for (int i = 1; i <= r; i++) begin
            a = (mrotl(a ^ b, b, w) + ms[2*i]) & m;
            b = (mrotl(b ^ a, a, w) + ms[2*i+1]) & m;
        end
        return {b, a};
    endfunction

    function automatic logic [127:0] model_dec(input logic [63:0] a0, input logic [63:0] b0,
                                               input int w, input int r);
        logic [63:0] a, b, m;
        m = msk(w);
        a = a0; b = b0;
        for (int i = r; i >= 1; i--) begin
            b = mrotr((b - ms[2*i+1]) & m, a, w) ^ a;
            a = mrotr((a - ms[2*i]) & m, b, w) ^ b;
        end
        b = (b - ms[1]) & m;
        a = (a - ms[0]) & m;
        return {b, a};
    endfunction

    function automatic int exp_kl(input int r, input int c);
        int t;
        t = 2 * r + 2;
        return t + 3 * ((t > c) ? t : c);
    endfunction

    // ---------------- W=16 drivers ----------------
    task automatic load16(input logic [127:0] k, input int r, output int lat);
        key16 = k; nr16 = 5'(r); kl16 = 1'b1;
        tick;
        kl16 = 1'b0;
        lat = 0;
        do begin tick; lat++; end while (!kr16 && lat < 2000);
    endtask

    task automatic run16(input logic m, input logic [31:0] din, output logic [31:0] dout, output int lat);
        check("in_ready_before_block", ir16, 1);
        md16 = m; di16 = din; iv16 = 1'b1;
        tick;
        iv16 = 1'b0; md16 = ~m; di16 = ~din;
        check("busy_after_accept", bz16, 1);
        lat = 0;
        do begin tick; lat++; end while (!ov16 && lat < 200);
        dout = do16;
        or16 = 1'b1;
        tick;
        or16 = 1'b0;
        check("out_valid_cleared", ov16, 0);
    endtask

    typedef struct {
        logic [127:0] key;
        int           r;
        logic [31:0]  din;
        logic [31:0]  exp_ct;
        int           exp_kl;
    } vec_t;

    localparam int NV = 12;
    vec_t tbl [NV];

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] res;
        logic [31:0]  dout, dout2, hold;
        logic [63:0]  d32;
        int           lat;
        bit           seen;

        rst = 1'b0;
        kl16 = 0; key16 = '0; nr16 = '0; iv16 = 0; md16 = 0; di16 = '0; or16 = 0;
        kl32 = 0; key32 = '0; nr32 = '0; iv32 = 0; md32 = 0; di32 = '0; or32 = 0;
        tick; tick;
        check("reset_flags16", {kr16, ce16, ir16, ov16, bz16}, 0);
        check("reset_dout16", do16, 0);
        check("reset_flags32", {kr32, ce32, ir32, ov32, bz32}, 0);
        rst = 1'b1;
        tick;

        // W=32, zero key, R=12
        key32 = '0; nr32 = 5'd12; kl32 = 1'b1;
        tick;
        kl32 = 1'b0;
        lat = 0;
        do begin tick; lat++; end while (!kr32 && lat < 2000);
        check("w32_key_lat", lat, exp_kl(12, 4));
        model_ks(256'(0), 16, 32, 12);
        for (int m = 0; m < 2; m++) begin
            md32 = m[0];
            di32 = (m == 0) ? 64'd0 : d32;
            iv32 = 1'b1;
            tick;
            iv32 = 1'b0; di32 = '1;
            lat = 0;
            do begin tick; lat++; end while (!ov32 && lat < 200);
            check("w32_out_lat", lat, 13);
            if (m == 0) begin
                res = model_enc(64'd0, 64'd0, 32, 12);
                check("w32_enc", do32, {res[95:64], res[31:0]});
                d32 = do32;
            end else begin
                check("w32_dec", do32, 64'd0);
            end
            or32 = 1'b1;
            tick;
            or32 = 1'b0;
        end

        // vector table: fixed corners then random entries
        tbl[0] = '{128'h0F0E0D0C0B0A09080706050403020100, 12, 32'h01234567, 32'h0, 0};
        tbl[1] = '{128'h0F0E0D0C0B0A09080706050403020100, 0,  32'h00010002, 32'h0, 0};
        tbl[2] = '{128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF, 20, 32'hFFFFFFFF, 32'h0, 0};
        tbl[3] = '{128'h0, 1, 32'h80000001, 32'h0, 0};
        for (int v = 4; v < NV; v++) begin
            tbl[v].key = {$urandom(), $urandom(), $urandom(), $urandom()};
            tbl[v].r   = int'($urandom_range(0, 20));
            tbl[v].din = $urandom();
        end
        for (int v = 0; v < NV; v++) begin
            model_ks(256'(tbl[v].key), 16, 16, tbl[v].r);
            res = model_enc(64'(tbl[v].din[15:0]), 64'(tbl[v].din[31:16]), 16, tbl[v].r);
            tbl[v].exp_ct = {res[79:64], res[15:0]};
            tbl[v].exp_kl = exp_kl(tbl[v].r, 8);
        end

        for (int v = 0; v < NV; v++) begin
            load16(tbl[v].key, tbl[v].r, lat);
            check($sformatf("v%0d_key_lat", v), lat, tbl[v].exp_kl);
            run16(1'b0, tbl[v].din, dout, lat);
            check($sformatf("v%0d_enc_lat", v), lat, tbl[v].r + 1);
            check($sformatf("v%0d_enc", v), dout, tbl[v].exp_ct);
            run16(1'b1, dout, dout2, lat);
            check($sformatf("v%0d_dec_lat", v), lat, tbl[v].r + 1);
            check($sformatf("v%0d_dec", v), dout2, tbl[v].din);
        end

        // backpressure with a second block waiting
        load16(tbl[0].key, 12, lat);
        model_ks(256'(tbl[0].key), 16, 16, 12);
        res = model_dec(64'hF00D, 64'hCAFE, 16, 12);
        md16 = 1'b1; di16 = 32'hCAFEF00D; iv16 = 1'b1;
        tick;
        di16 = 32'h12345678; md16 = 1'b0;
        lat = 0;
        do begin tick; lat++; end while (!ov16 && lat < 200);
        check("bp_lat", lat, 13);
        hold = do16;
        check("bp_data", hold, {res[79:64], res[15:0]});
        for (int c = 0; c < 10; c++) begin
            tick;
            check("bp_hold", do16, hold);
            check("bp_in_ready", {ov16, ir16}, 2'b10);
        end
        iv16 = 1'b0; or16 = 1'b1;
        tick;
        or16 = 1'b0;
        check("bp_release", {ov16, bz16, ir16}, 3'b001);
        seen = 0;
        for (int c = 0; c < 20; c++) begin tick; if (ov16 || bz16) seen = 1; end
        check("bp_one_transfer", seen, 0);

        // illegal round count, then valid reload
        nr16 = 5'd21; kl16 = 1'b1;
        tick;
        kl16 = 1'b0;
        check("cfg_err_set", {ce16, kr16, ir16, bz16}, 4'b1000);
        tick;
        check("cfg_err_sticky", {ce16, kr16, ir16}, 3'b100);
        load16(tbl[0].key, 12, lat);
        check("cfg_reload_lat", lat, exp_kl(12, 8));
        check("cfg_err_cleared", {ce16, kr16}, 2'b01);

        // key_load together with in_valid in READY
        nr16 = 5'd5; key16 = tbl[1].key; kl16 = 1'b1; iv16 = 1'b1; di16 = 32'h1111;
        #1;
        check("kl_blocks_in_ready", ir16, 0);
        tick;
        kl16 = 1'b0; iv16 = 1'b0;
        seen = 0; lat = 0;
        do begin tick; lat++; if (ov16) seen = 1; end while (!kr16 && lat < 2000);
        check("kl_ready_lat", lat, exp_kl(5, 8));
        check("kl_ready_no_out", seen, 0);

        // key_load mid-round drops the block
        md16 = 1'b0; di16 = 32'h5A5A0F0F; iv16 = 1'b1;
        tick;
        iv16 = 1'b0;
        tick; tick; tick;
        nr16 = 5'd7; key16 = tbl[2].key; kl16 = 1'b1;
        tick;
        kl16 = 1'b0;
        check("drop_state", {ov16, kr16, bz16}, 3'b001);
        seen = 0; lat = 0;
        do begin tick; lat++; if (ov16) seen = 1; end while (!kr16 && lat < 2000);
        check("drop_key_lat", lat, exp_kl(7, 8));
        check("drop_no_out_valid", seen, 0);
        model_ks(256'(tbl[2].key), 16, 16, 7);
        res = model_enc(64'h0F0F, 64'h5A5A, 16, 7);
        run16(1'b0, 32'h5A5A0F0F, dout, lat);
        check("drop_then_enc", dout, {res[79:64], res[15:0]});

        // async reset during KEY_MIX
        nr16 = 5'd12; kl16 = 1'b1;
        tick;
        kl16 = 1'b0;
        repeat (30) tick;
        check("mix_busy", {bz16, kr16}, 2'b10);
        rst = 1'b0;
        #1;
        check("rst_async", {kr16, ce16, ir16, ov16, bz16}, 0);
        tick;
        check("rst_next_cycle", {kr16, ce16, ir16, ov16, bz16}, 0);
        check("rst_dout", do16, 0);
        rst = 1'b1;
        repeat (5) tick;
        check("rst_needs_reload", {kr16, bz16, ir16}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
